segment_display_ctrl: RTL and testbench

- Parametrised multi-digit 7-segment controller: accepts a binary value via valid/ready handshake and renders it on NUM_DIGITS static active-low digits.
- Renders in hex or decimal mode; decimal uses a sequential double-dabble binary-to-BCD converter.
- Adds leading-zero blanking, overflow detection ("E" on every digit) and a completion pulse.
- Sits between register/CSR logic and board segment pins.

---
 rtl/segment_pkg.sv | 39 +++
 rtl/seg_bin2bcd_seq.sv | 61 ++++++
 rtl/segment_display_ctrl.sv | 123 ++++++++++++
 tb/tb_segment_display_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/segment_pkg.sv
// Shared types, segment constants and the nibble-to-segment encoder for the
// 7-segment display controller.
package segment_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;

  // Active-low a..g codes; in decimal mode a non-BCD nibble is shown as "E".
  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib, input logic dec_only);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h18;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    if (dec_only && nib > 4'd9) seg = SEG_E;
    return seg;
  endfunction

endpackage

// File: rtl/seg_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle for
// VALUE_WIDTH cycles, with a sticky flag for bits lost off the top digit.
module seg_bin2bcd_seq #(
  parameter int VALUE_WIDTH = 16,
  parameter int NUM_DIGITS  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [VALUE_WIDTH-1:0]  bin_in,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    ovf,
  output logic                    done
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(VALUE_WIDTH + 1);

  logic [VALUE_WIDTH-1:0] bin_q;
  logic [BW-1:0]          bcd_q;
  logic [BW-1:0]          bcd_adj;
  logic [CW-1:0]          cnt_q;
  logic                   ovf_q;
  logic                   busy_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else if (start) begin
      bin_q  <= bin_in;
      bcd_q  <= '0;
      cnt_q  <= CW'(VALUE_WIDTH);
      ovf_q  <= 1'b0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
      ovf_q          <= ovf_q | bcd_adj[BW-1];
      cnt_q          <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  // done flags the cycle of the final shift so the caller can commit next cycle.
  assign busy    = busy_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;
  assign done    = busy_q && (cnt_q == CW'(1));

endmodule

// File: rtl/segment_display_ctrl.sv
// Multi-digit static 7-segment controller: hex or decimal rendering with
// leading-zero blanking, overflow "E" display and a commit pulse.
module segment_display_ctrl
  import segment_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [VALUE_WIDTH-1:0]  value_in,
  input  logic                    mode_dec,
  input  logic                    blank_lz,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [NUM_DIGITS*7-1:0] seg_out,
  output logic                    overflow,
  output logic                    done
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int PW = (VALUE_WIDTH > BW) ? VALUE_WIDTH : BW;

  state_e                  state_q;
  logic [VALUE_WIDTH-1:0]  val_q;
  logic                    dec_q;
  logic                    blank_q;
  logic                    ready_q;
  logic [NUM_DIGITS*7-1:0] seg_q;
  logic                    ovf_q;
  logic                    done_q;

  logic [NUM_DIGITS*7-1:0] seg_d;
  logic                    ovf_d;
  logic [PW-1:0]           val_pad;
  logic [3:0]              nib;
  logic                    lead;

  logic                    conv_start;
  logic                    conv_busy;
  logic                    conv_ovf;
  logic                    conv_done;
  logic [BW-1:0]           conv_bcd;

  assign conv_start = (state_q == IDLE) && load_valid && mode_dec;

  seg_bin2bcd_seq #(
    .VALUE_WIDTH(VALUE_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .reset  (reset),
    .start  (conv_start),
    .bin_in (value_in),
    .busy   (conv_busy),
    .bcd_out(conv_bcd),
    .ovf    (conv_ovf),
    .done   (conv_done)
  );

  assign val_pad = PW'(val_q);

  // Walk from the top digit down so blanking stops at the first nonzero digit.
  always_comb begin
    ovf_d = dec_q ? conv_ovf : |(val_pad >> BW);
    seg_d = '0;
    nib   = '0;
    lead  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib = dec_q ? conv_bcd[4*i +: 4] : val_pad[4*i +: 4];
      if (nib != 4'd0) lead = 1'b0;
      if (ovf_d)                          seg_d[7*i +: 7] = SEG_E;
      else if (blank_q && lead && i != 0) seg_d[7*i +: 7] = SEG_BLANK;
      else                                seg_d[7*i +: 7] = nibble_to_seg(nib, dec_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      dec_q   <= 1'b0;
      blank_q <= 1'b0;
      ready_q <= 1'b1;
      seg_q   <= {NUM_DIGITS{SEG_BLANK}};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            val_q   <= value_in;
            dec_q   <= mode_dec;
            blank_q <= blank_lz;
            ready_q <= 1'b0;
            state_q <= mode_dec ? CONVERT : COMMIT;
          end
        end
        CONVERT: begin
          if (conv_done || !conv_busy) state_q <= COMMIT;
        end
        COMMIT: begin
          seg_q   <= seg_d;
          ovf_q   <= ovf_d;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign load_ready = ready_q;
  assign seg_out    = seg_q;
  assign overflow   = ovf_q;
  assign done       = done_q;

endmodule

// File: tb/tb_segment_display_ctrl.sv
// Self-checking bench for segment_display_ctrl: directed and randomized loads
// compared against an arithmetic digit-extraction model.
module tb_segment_display_ctrl;

  localparam int ND = 4;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [VW-1:0] value_in;
  logic          mode_dec;
  logic          blank_lz;
  logic          load_valid;
  logic          load_ready;
  logic [ND*7-1:0] seg_out;
  logic          overflow;
  logic          done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  segment_display_ctrl #(.NUM_DIGITS(ND), .VALUE_WIDTH(VW)) dut (
    .clk       (clk),
    .reset     (reset),
    .value_in  (value_in),
    .mode_dec  (mode_dec),
    .blank_lz  (blank_lz),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .seg_out   (seg_out),
    .overflow  (overflow),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference: split the value into base-10/16 digits arithmetically.
  function automatic void model(input longint unsigned v, input bit dec, input bit blank,
                                output logic [ND*7-1:0] exp_seg, output bit exp_ovf);
    longint unsigned base, lim, rem;
    int dig [ND];
    int msd;
    base = dec ? 10 : 16;
    lim  = 1;
    for (int i = 0; i < ND; i++) lim = lim * base;
    exp_ovf = (v >= lim);
    rem = v;
    msd = 0;
    for (int i = 0; i < ND; i++) begin
      dig[i] = int'(rem % base);
      rem    = rem / base;
      if (dig[i] != 0) msd = i;
    end
    exp_seg = '0;
    for (int i = 0; i < ND; i++) begin
      if (exp_ovf)              exp_seg[7*i +: 7] = 7'h06;
      else if (blank && i > msd) exp_seg[7*i +: 7] = 7'h7F;
      else                       exp_seg[7*i +: 7] = seg_tab[dig[i]];
    end
  endfunction

  // Called just after a negedge; the handshake edge is the next posedge.
  task automatic send(input logic [VW-1:0] v, input bit d, input bit b);
    value_in   = v;
    mode_dec   = d;
    blank_lz   = b;
    load_valid = 1'b1;
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; value_in = '0; mode_dec = 1'b0; blank_lz = 1'b0; load_valid = 1'b0;
    #2;
    tests_run++;
    if (seg_out !== {ND{7'h7F}}) begin
      tests_failed++; $display("[TB] FAIL reset_seg: got %h expected %h", seg_out, {ND{7'h7F}});
    end
    tests_run++;
    if (overflow !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL reset_flags: got ovf=%b done=%b ready=%b expected 0 0 1", overflow, done, load_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (load_ready !== 1'b1 || seg_out !== {ND{7'h7F}}) begin
      tests_failed++; $display("[TB] FAIL reset_release: got ready=%b seg=%h expected 1 %h", load_ready, seg_out, {ND{7'h7F}});
    end
  endtask

  task automatic test_hex();
    logic [VW-1:0] vals [4] = '{16'h1A3F, 16'h0007, 16'h00F0, 16'hFFFF};
    bit            blks [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [ND*7-1:0] es;
    bit eo;
    int dones;
    for (int n = 0; n < 4; n++) begin
      model(longint'(vals[n]), 1'b0, blks[n], es, eo);
      send(vals[n], 1'b0, blks[n]);
      dones = 0;
      @(negedge clk);
      if (done === 1'b1) dones++;
      tests_run++;
      if (load_ready !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL hex_busy_ready[%0d]: got %b expected 0", n, load_ready);
      end
      @(negedge clk);
      if (done === 1'b1) dones++;
      tests_run++;
      if (seg_out !== es || overflow !== eo) begin
        tests_failed++; $display("[TB] FAIL hex_seg[%0d]: got %h ovf=%b expected %h ovf=%b", n, seg_out, overflow, es, eo);
      end
      @(negedge clk);
      if (done === 1'b1) dones++;
      tests_run++;
      if (dones != 1) begin
        tests_failed++; $display("[TB] FAIL hex_done_count[%0d]: got %0d expected 1", n, dones);
      end
    end
  endtask

  task automatic test_decimal();
    logic [VW-1:0] vals [6] = '{16'd1234, 16'd10000, 16'd42, 16'd0, 16'd9999, 16'd65535};
    bit            blks [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [ND*7-1:0] es;
    bit eo;
    int dones;
    bit busy_bad;
    for (int n = 0; n < 6; n++) begin
      model(longint'(vals[n]), 1'b1, blks[n], es, eo);
      send(vals[n], 1'b1, blks[n]);
      dones = 0;
      busy_bad = 1'b0;
      for (int k = 1; k <= VW + 2; k++) begin
        @(negedge clk);
        if (done === 1'b1) dones++;
        if (k <= VW + 1 && load_ready !== 1'b0) busy_bad = 1'b1;
      end
      tests_run++;
      if (busy_bad) begin
        tests_failed++; $display("[TB] FAIL dec_ready_low[%0d]: got ready high while busy expected low", n);
      end
      tests_run++;
      if (seg_out !== es || overflow !== eo) begin
        tests_failed++; $display("[TB] FAIL dec_seg[%0d]: got %h ovf=%b expected %h ovf=%b", n, seg_out, overflow, es, eo);
      end
      tests_run++;
      if (done !== 1'b1 || dones != 1) begin
        tests_failed++; $display("[TB] FAIL dec_done[%0d]: got done=%b count=%0d expected 1 1", n, done, dones);
      end
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] v;
    bit d, b, eo;
    logic [ND*7-1:0] es;
    int lat;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: v = VW'($urandom_range(0, 15));
        1: v = VW'($urandom_range(0, 9999));
        2: v = VW'($urandom_range(9990, 10010));
        default: v = VW'($urandom);
      endcase
      d = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      model(longint'(v), d, b, es, eo);
      lat = d ? VW + 2 : 2;
      send(v, d, b);
      repeat (lat - 1) @(negedge clk);
      tests_run++;
      if (done !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL rand_early_done[%0d]: got %b expected 0", n, done);
      end
      @(negedge clk);
      tests_run++;
      if (seg_out !== es || overflow !== eo || done !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL rand_seg[%0d] v=%0d dec=%b blk=%b: got %h ovf=%b done=%b expected %h ovf=%b done=1",
                 n, v, d, b, seg_out, overflow, done, es, eo);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [ND*7-1:0] ea, eb;
    bit oa, ob;
    int dones;
    model(64'd1234, 1'b1, 1'b0, ea, oa);
    model(64'hBEEF, 1'b0, 1'b0, eb, ob);
    value_in = 16'd1234; mode_dec = 1'b1; blank_lz = 1'b0; load_valid = 1'b1;
    @(posedge clk);
    #1 value_in = 16'hBEEF; mode_dec = 1'b0;
    dones = 0;
    for (int k = 1; k <= VW + 1; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    tests_run++;
    if (dones != 0) begin
      tests_failed++; $display("[TB] FAIL b2b_ignored_load: got %0d early done pulses expected 0", dones);
    end
    @(negedge clk);
    tests_run++;
    if (seg_out !== ea || overflow !== oa || done !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL b2b_first: got %h done=%b expected %h done=1", seg_out, done, ea);
    end
    @(posedge clk);
    #1 load_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (seg_out !== ea || done !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL b2b_hold: got %h done=%b expected %h done=0", seg_out, done, ea);
    end
    @(negedge clk);
    tests_run++;
    if (seg_out !== eb || overflow !== ob || done !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL b2b_second: got %h done=%b expected %h done=1", seg_out, done, eb);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    bit seg_bad;
    send(16'd1234, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (seg_out !== {ND{7'h7F}} || overflow !== 1'b0 || done !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL midreset_outputs: got %h ovf=%b done=%b expected %h 0 0", seg_out, overflow, done, {ND{7'h7F}});
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    seg_bad = 1'b0;
    @(negedge clk);
    tests_run++;
    if (load_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL midreset_ready: got %b expected 1", load_ready);
    end
    for (int k = 0; k < VW + 4; k++) begin
      if (done === 1'b1) dones++;
      if (seg_out !== {ND{7'h7F}}) seg_bad = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (dones != 0 || seg_bad) begin
      tests_failed++; $display("[TB] FAIL midreset_no_commit: got %0d done pulses seg_changed=%b expected 0 0", dones, seg_bad);
    end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_decimal();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
